// File: rtl/dac_cmd_assembler_if.sv
// dac_cmd_assembler_if: adapter-side register write bus and DAC-side word handshake.
interface dac_cmd_assembler_if;
    logic [3:0]  s_data;
    logic [3:0]  s_addr;
    logic [15:0] m_word;
    logic        m_valid;
    logic        m_ready;
    modport master (output s_data, s_addr, m_ready, input m_word, m_valid);
    modport slave  (input s_data, s_addr, m_ready, output m_word, m_valid);
endinterface

// File: rtl/dac_cmd_assembler.sv
// dac_cmd_assembler: turns nibble register writes into queued 16-bit DAC words.
// Define DAC_CMD_DROP_CNT_EN to add the saturating dropped-commit counter port.
module dac_cmd_assembler #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] COMMIT_ADDR = 4'h4,
    parameter logic [3:0] CTRL_ADDR   = 4'h5
) (
    input  logic                          aclk,
    input  logic                          arst_n,
    dac_cmd_assembler_if.slave            bus,
    output logic                          enable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DAC_CMD_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic {DISABLED, RUN} state_t;

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [7:0]    r1, r2;
    logic [15:0]   staging;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [15:0]   head;
    state_t        state;
    logic          ev, commit, ctrl, flush, full, valid, pop, push;

    // Assertion is immediate; release waits two edges so no flop sees a runt reset.
    always_ff @(posedge aclk or negedge arst_n)
        if (!arst_n) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n  = rst_sync[1];
    assign ev     = r1 != r2;
    assign commit = ev && r1[7:4] == COMMIT_ADDR;
    assign ctrl   = ev && r1[7:4] == CTRL_ADDR;
    assign flush  = ctrl && state == RUN && !r1[0];
    assign full   = fifo_level == FULL;
    assign valid  = enable && fifo_level != '0;
    assign pop    = valid && bus.m_ready;
    assign push   = commit && state == RUN && (!full || pop);

    assign bus.m_valid = valid;
    assign bus.m_word  = head;

    always_ff @(posedge aclk or negedge rst_n)
        if (!rst_n) begin
            r1 <= '0;
            r2 <= '0;
        end else begin
            r1 <= {bus.s_addr, bus.s_data};
            r2 <= r1;
        end

    always_ff @(posedge aclk or negedge rst_n)
        if (!rst_n)                     staging <= '0;
        else if (ev && r1[7:6] == 2'b00) staging[{r1[5:4], 2'b00} +: 4] <= r1[3:0];

    always_ff @(posedge aclk or negedge rst_n)
        if (!rst_n) begin
            state  <= DISABLED;
            enable <= 1'b0;
        end else if (ctrl) begin
            state  <= r1[0] ? RUN : DISABLED;
            enable <= r1[0];
        end

    always_ff @(posedge aclk)
        if (push) mem[wr_ptr] <= staging;

    // head is a register so an empty queue keeps presenting the last word.
    always_ff @(posedge aclk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            head       <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            if (pop && fifo_level > ONE)                     head <= mem[rd_ptr + AW'(1)];
            else if (push && (pop || fifo_level == '0))      head <= staging;
        end

`ifdef DAC_CMD_DROP_CNT_EN
    logic drop;
    assign drop = commit && state == RUN && full && !pop;

    always_ff @(posedge aclk or negedge rst_n)
        if (!rst_n)                         drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
endmodule

// File: doc/dac_cmd_assembler.md
DAC_CMD_ASSEMBLER -- requirements
Module: dac_cmd_assembler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output word queue depth (power of 2, >=2).
REQ-002 SHALL have parameter COMMIT_ADDR, default 4'h4, address whose write event commits the staging word.
REQ-003 SHALL have parameter CTRL_ADDR, default 4'h5, address whose write event loads control; data[0] = enable.
REQ-004 SHALL have port aclk  input  1  sole clock; all logic is on its rising edge.
REQ-005 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_data  input  4  nibble from the JTAG/AXI-Lite adapter data output, synchronous to aclk.
REQ-007 SHALL have port s_addr  input  4  register address from the adapter address output, synchronous to aclk.
REQ-008 SHALL have port m_word  output  16  queue head, the DAC/MASH input word.
REQ-009 SHALL have port m_valid  output  1  queue non-empty and enabled.
REQ-010 SHALL have port m_ready  input  1  downstream accepts m_word when m_valid&&m_ready at a rising edge.
REQ-011 SHALL have port enable  output  1  current control enable bit.
REQ-012 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued words.
REQ-013 SHALL have port drop_cnt  output  8  dropped-commit counter (present only with DAC_CMD_DROP_CNT_EN).

Function
REQ-014 SHALL register {s_addr,s_data} into stage r1 each edge and r1 into r2; a write event SHALL exist in a cycle where r1 != r2.
REQ-015 SHALL take the event action on the edge following event detection: a visible effect lags an input change by 2 edges.
REQ-016 Repeated identical {addr,data} SHALL produce no event; consecutive host writes must differ in addr or data.
REQ-017 Event with addr 0..3 SHALL write data into staging nibble addr (addr 0 = bits 3:0, addr 3 = bits 15:12); other nibbles held.
REQ-018 Event with addr COMMIT_ADDR SHALL push the full 16-bit staging word into the queue; staging not cleared; data value ignored.
REQ-019 Event with addr CTRL_ADDR SHALL load enable <= data[0]; other addresses SHALL be ignored.
REQ-020 FSM SHALL have states DISABLED (enable=0) and RUN (enable=1); CTRL event data[0]=1 moves DISABLED->RUN, data[0]=0 moves RUN->DISABLED.
REQ-021 On RUN->DISABLED the queue SHALL be flushed on the same edge (fifo_level=0); commits in DISABLED SHALL be discarded and not counted.
REQ-022 m_valid SHALL be 1 only in RUN with fifo_level>0; pop SHALL occur on edge with m_valid&&m_ready.
REQ-023 Commit with queue full and no simultaneous pop SHALL be dropped, queue unchanged.
REQ-024 Commit with queue full and simultaneous pop SHALL be accepted; level unchanged, order preserved.
REQ-025 Commit with queue empty SHALL produce m_valid=1 and m_word=staging word on the same edge (no extra bypass latency).
REQ-026 m_word SHALL be stable while m_valid&&!m_ready; when empty it SHALL hold the last head value (0 after reset).
REQ-027 Queue pointers SHALL wrap modulo FIFO_DEPTH; FIFO order strictly preserved.

Reset
REQ-028 arst_n low SHALL immediately clear r1, r2, staging, queue, m_word, fifo_level, drop_cnt to 0 and enter DISABLED (enable=0, m_valid=0).
REQ-029 Reset deassertion SHALL be synchronised internally; the reset pair {0,0} SHALL not form an event.
REQ-030 Reset asserted mid-transfer SHALL discard queued and staged words without emitting a partial handshake.

Configuration
REQ-031 With DAC_CMD_DROP_CNT_EN defined, drop_cnt SHALL increment (saturating at 255) per REQ-023 drop; cleared only by reset.
REQ-032 Without DAC_CMD_DROP_CNT_EN, port drop_cnt and its counter SHALL be absent; drops are silent.

Verification
REQ-033 Writes addr0..3 = 1,2,3,4, CTRL data 1, COMMIT -> m_valid=1, m_word=16'h4321 two edges after commit input change.
REQ-034 m_ready=0, 5 commits of distinct words, FIFO_DEPTH=4 -> fifo_level=4, first 4 words output in order, drop_cnt=1.
REQ-035 Queue full, commit coincident with m_ready=1 pop -> level stays 4, new word emitted fourth.
REQ-036 Same {addr,data} held 10 cycles -> exactly one event, one push.
REQ-037 Level 3, CTRL data 0 -> fifo_level=0, m_valid=0 next edge; subsequent commit ignored, drop_cnt unchanged.
REQ-038 arst_n pulsed low mid-queue with m_valid=1 -> all outputs 0 asynchronously, no pop after release.
